// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and
// the bit-counter width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full adder built from two half-add stages and a carry OR;
// the serial controller time-shares one instance across all bit positions.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB first over
// WIDTH cycles. Define SERIAL_ADD_SUB_EN to add the 'sub' (a - b) mode.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

  serial_fa_cell u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // Subtraction is a + ~b + 1, so only the captured B operand and carry change.
  always_comb begin
    b_cap = op_b;
    c_cap = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_cap = ~op_b;
      c_cap = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // FIN accepts a new start directly, giving back-to-back operation.
        IDLE, FIN: begin
          if (start) begin
            a_sr  <= op_a;
            b_sr  <= b_cap;
            carry <= c_cap;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_sr <= {cell_s, res_sr[WIDTH-1:1]};
          carry  <= cell_co;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          if (cnt == LAST) begin
            sum   <= {cell_s, res_sr[WIDTH-1:1]};
            cout  <= cell_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard testbench for serial_add_ctrl: stimulus pushes expected results
// from an arithmetic reference model, a monitor checks them on every done.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub = 1'b0;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               done_count = 0;
  logic [WIDTH-1:0] held_sum = '0;
  logic             held_cout = 1'b0;
  exp_t             q[$];
  exp_t             mon_e;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition, or a - b with "no borrow" as cout.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic s, input int dcyc);
    exp_t        r;
    int unsigned ai;
    int unsigned bi;
    int unsigned total;
    ai = 32'(a);
    bi = 32'(b);
    if (s) begin
      r.sum  = WIDTH'(ai - bi);
      r.cout = (ai >= bi);
    end else begin
      total  = ai + bi + 32'(c);
      r.sum  = WIDTH'(total);
      r.cout = (total >> WIDTH) != 0;
    end
    r.cyc = dcyc;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      if (q.size() == 0) begin
        checkOutput("unexpected_done", 64'(1), 64'(0));
      end else begin
        mon_e = q.pop_front();
        checkOutput("sum", 64'(sum), 64'(mon_e.sum));
        checkOutput("cout", 64'(cout), 64'(mon_e.cout));
        checkOutput("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        held_sum  = mon_e.sum;
        held_cout = mon_e.cout;
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic c, input logic s);
    op_a  = a;
    op_b  = b;
    cin   = c;
`ifdef SERIAL_ADD_SUB_EN
    sub   = s;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    q.push_back(model(a, b, c, s, cyc + WIDTH));
  endtask

  task automatic waitDone(output int busy_cycles, output int held_bad);
    bit seen;
    seen        = 0;
    busy_cycles = 0;
    held_bad    = 0;
    for (int n = 0; n < 3 * WIDTH; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_cycles++;
      if (sum !== held_sum || cout !== held_cout) held_bad++;
    end
    if (!seen) checkOutput("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic finishOp();
    int bc;
    int hb;
    waitDone(bc, hb);
    checkOutput("busy_cycles", 64'(bc), 64'(WIDTH));
    checkOutput("sum_held_in_run", 64'(hb), 64'(0));
    checkOutput("busy_at_done", 64'(busy), 64'(0));
  endtask

  task automatic idleStep();
    @(negedge clk);
    checkOutput("done_single_pulse", 64'(done), 64'(0));
    checkOutput("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic s);
    applyStimulus(a, b, c, s);
    finishOp();
  endtask

  initial begin
    int bc;
    int hb;
    int d0;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rc;
    logic rs;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_sum", 64'(sum), 64'(0));
    checkOutput("reset_cout", 64'(cout), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    runOp(8'h5A, 8'h33, 1'b0, 1'b0);
    idleStep();
    runOp(8'hFF, 8'h01, 1'b0, 1'b0);
    idleStep();
    runOp(8'hFF, 8'h00, 1'b1, 1'b0);
    idleStep();

    // A start raised mid-run must not disturb the running operation.
    applyStimulus(8'h12, 8'h34, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    op_a  = 8'hAA;
    op_b  = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(bc, hb);
    checkOutput("ignored_start_held", 64'(hb), 64'(0));
    @(negedge clk);
    d0 = done_count;
    repeat (WIDTH + 3) @(negedge clk);
    checkOutput("no_extra_done", 64'(done_count - d0), 64'(0));

    // Reset in the middle of a run discards the operation.
    applyStimulus(8'h77, 8'h99, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    held_sum  = '0;
    held_cout = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'(0));
    checkOutput("midreset_done", 64'(done), 64'(0));
    checkOutput("midreset_sum", 64'(sum), 64'(0));
    checkOutput("midreset_cout", 64'(cout), 64'(0));
    d0 = done_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 3) @(negedge clk);
    checkOutput("midreset_no_done", 64'(done_count - d0), 64'(0));
    runOp(8'h3C, 8'h0F, 1'b1, 1'b0);
    idleStep();

    // Start held in the FIN cycle is accepted with no idle gap.
    runOp(8'hC8, 8'h64, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
    finishOp();
    idleStep();

`ifdef SERIAL_ADD_SUB_EN
    runOp(8'h05, 8'h07, 1'b0, 1'b1);
    idleStep();
    runOp(8'h07, 8'h05, 1'b1, 1'b1);
    idleStep();
`endif

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      runOp(ra, rb, rc, rs);
      if ($urandom_range(0, 1) == 1) idleStep();
    end
    idleStep();

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
